commit_buffer_v2: RTL and testbench
===================================

# commit_buffer_v2

Eight-entry in-order commit buffer for the 2-wide superscalar core. It sits directly upstream of the dual-write-port register file. It allocates up to two entries per cycle in program order and accepts up to two out-of-order execution results per cycle, tagged by entry index. It retires up to two completed entries per cycle, in order, onto the register file's two write ports.

## Interface
Parameters:
- DEPTH, 8, number of entries (fixed; pointers are 3-bit index plus wrap bit)
- DW, 16, data width

Ports:
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- flush  in  1  discard all entries (pipeline squash)
- alloc_valid0  in  1  allocate older instruction of the dispatch pair
- alloc_valid1  in  1  allocate younger instruction; honoured only with alloc_valid0
- alloc_writes0/1  in  1 each  instruction writes a register
- alloc_dest0/1  in  3 each  destination register address
- alloc_ready  out  1  at least 2 free entries (combinational from registered count)
- alloc_tag0/1  out  3 each  index that slot 0/1 receives if allocated (tail, tail+1 mod 8)
- wb_valid0/1  in  1 each  execution result valid
- wb_tag0/1  in  3 each  entry index of result
- wb_data0/1  in  DW each  result value
- commit_we0/1  out  1 each  register write enable to register file port 0/1
- commit_addr0/1  out  3 each  register write address
- commit_data0/1  out  DW each  register write data
- commit_count  out  2  entries retired this cycle (0..2)
- empty  out  1  count == 0
- full  out  1  count == 8

## Operation
- Per entry: valid, done, writes, dest[2:0], data[15:0]. Head, tail: 4-bit pointers (index + wrap). Count: 4-bit, 0..8.
- Allocation:
  - Occurs on an edge only when alloc_ready=1 and alloc_valid0=1.
  - Slot 0 goes to tail. Slot 1 goes to tail+1 if alloc_valid1=1.
  - Each new entry: valid=1, done=0. Tail advances by 1 or 2.
  - alloc_valid1 without alloc_valid0 is ignored.
- Writeback:
  - wb_validN to a valid entry sets done=1 and stores wb_dataN.
  - A writeback to an invalid entry is ignored.
  - Both ports naming the same tag in one cycle: port 1 wins.
  - A writeback to an entry allocated on the same edge is ignored.
- Commit:
  - Evaluated from registered state. Slot 0 retires if head is valid and done. Slot 1 retires if slot 0 retires and head+1 is valid and done.
  - A retiring entry drives commit_weN = writes, commit_addrN = dest, commit_dataN = data. Its valid is cleared and head advances by commit_count.
  - Non-retiring slots drive we=0, addr=0, data=0.
  - Both slots retiring to the same dest: both we asserted. Register-file port 1 priority gives the younger value.
- Count update: count_next = count + allocated − retired. Simultaneous allocation and commit are legal.
- Flush:
  - Clears all valid/done bits; head, tail and count go to 0; commit outputs go to 0 next cycle.
  - Overrides allocation, writeback and commit on the same edge.
- Reset (reset=0 at an edge): same as flush, plus all entry payloads zeroed. Reset has priority over flush. Reset mid-operation drops all in-flight entries.

## Timing
- Reset values: commit_we0/1=0, commit_addr0/1=0, commit_data0/1=0, commit_count=0, empty=1, full=0, alloc_ready=1, alloc_tag0=0, alloc_tag1=1.
- All commit_* outputs and commit_count are registered. They are valid for exactly one cycle after the retiring edge.
- Writeback at edge N sets done. The entry (if at head) appears on commit outputs after edge N+1. There is no same-cycle wb→commit bypass; minimum wb-to-regfile-write is 2 edges.
- Allocation at edge N makes the entry visible in count/empty/full after edge N.
- alloc_ready uses the pre-edge count only: count ≥ 7 gives alloc_ready=0 even if retirement frees entries that edge.
- Pointer wrap: index 7 → 0 with wrap-bit toggle. full = (index equal, wrap differ); empty = (pointers equal).

## Test plan
- Reset, then alloc pair (dest 3, dest 5, writes=1) → alloc_tag0=0/tag1=1. Then wb tag1=0xBEEF, then wb tag0=0x1234 → one cycle after the tag0 wb edge, commit_count=2, we0/1=1, addr0=3 data0=0x1234, addr1=5 data1=0xBEEF; empty=1 afterward.
- Allocate 4 pairs with no writebacks → full=1, alloc_ready=0 from count 7 onward. Further alloc_valid0 pulses are not accepted; tail is unchanged.
- Fill and drain 3 times with 2-per-cycle writeback/commit → tags wrap 6,7,0,1 correctly; commit order matches allocation order; no lost or duplicated entries.
- Alloc entry with writes=0, wb done → commit_count=1, commit_we0=0, entry freed.
- Both wb ports target tag 2 (0xAAAA on port 0, 0x5555 on port 1) → committed data=0x5555. Pair committing the same dest 4 → both we asserted, addr0=addr1=4.
- Pending done entries plus flush asserted with alloc_valid0=1 and wb_valid0=1 → next cycle empty=1, commit_count=0, nothing allocated. Repeat with reset=0 and flush=1 → reset values on all outputs.

Source files
------------

// File: rtl/commit_buffer_v2.sv
//------------------------------------------------------------------------------
// Module   : commit_buffer_v2
// Purpose  : Eight-entry in-order commit buffer, 2-wide alloc/writeback/retire.
// Revision : 2.0
//------------------------------------------------------------------------------
`default_nettype none

module commit_buffer_v2 #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          alloc_valid0,
  input  logic          alloc_valid1,
  input  logic          alloc_writes0,
  input  logic          alloc_writes1,
  input  logic [2:0]    alloc_dest0,
  input  logic [2:0]    alloc_dest1,
  output logic          alloc_ready,
  output logic [2:0]    alloc_tag0,
  output logic [2:0]    alloc_tag1,
  input  logic          wb_valid0,
  input  logic          wb_valid1,
  input  logic [2:0]    wb_tag0,
  input  logic [2:0]    wb_tag1,
  input  logic [DW-1:0] wb_data0,
  input  logic [DW-1:0] wb_data1,
  output logic          commit_we0,
  output logic          commit_we1,
  output logic [2:0]    commit_addr0,
  output logic [2:0]    commit_addr1,
  output logic [DW-1:0] commit_data0,
  output logic [DW-1:0] commit_data1,
  output logic [1:0]    commit_count,
  output logic          empty,
  output logic          full
);

  localparam logic [3:0] c_ALLOC_LIMIT = 4'd7;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_writes;
  logic [2:0]       r_dest [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [3:0]       r_head;
  logic [3:0]       r_tail;
  logic [3:0]       r_count;

  logic [2:0] w_h0;
  logic [2:0] w_h1;
  logic [2:0] w_t0;
  logic [2:0] w_t1;
  logic       w_ret0;
  logic       w_ret1;
  logic [1:0] w_ret_n;
  logic       w_alloc0;
  logic       w_alloc1;
  logic [1:0] w_alloc_n;

  assign w_h0 = r_head[2:0];
  assign w_h1 = r_head[2:0] + 3'd1;
  assign w_t0 = r_tail[2:0];
  assign w_t1 = r_tail[2:0] + 3'd1;

  // Retirement is decided purely from registered state: no wb->commit bypass.
  assign w_ret0  = r_valid[w_h0] & r_done[w_h0];
  assign w_ret1  = w_ret0 & r_valid[w_h1] & r_done[w_h1];
  assign w_ret_n = w_ret1 ? 2'd2 : (w_ret0 ? 2'd1 : 2'd0);

  // Gated on the pre-edge count, so entries freed this edge cannot be reused.
  assign alloc_ready = (r_count < c_ALLOC_LIMIT);
  assign alloc_tag0  = w_t0;
  assign alloc_tag1  = w_t1;
  assign w_alloc0    = alloc_ready & alloc_valid0;
  assign w_alloc1    = w_alloc0 & alloc_valid1;
  assign w_alloc_n   = w_alloc1 ? 2'd2 : (w_alloc0 ? 2'd1 : 2'd0);

  assign empty = (r_head == r_tail);
  assign full  = (r_head[2:0] == r_tail[2:0]) && (r_head[3] != r_tail[3]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid      <= '0;
      r_done       <= '0;
      r_writes     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_we0   <= 1'b0;
      commit_we1   <= 1'b0;
      commit_addr0 <= '0;
      commit_addr1 <= '0;
      commit_data0 <= '0;
      commit_data1 <= '0;
      commit_count <= '0;
    end else if (flush) begin
      r_valid      <= '0;
      r_done       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_we0   <= 1'b0;
      commit_we1   <= 1'b0;
      commit_addr0 <= '0;
      commit_addr1 <= '0;
      commit_data0 <= '0;
      commit_data1 <= '0;
      commit_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Later assignments win: port 1 over port 0, retire/alloc over writeback.
        if (wb_valid0 && (wb_tag0 == 3'(i)) && r_valid[i]) begin
          r_done[i] <= 1'b1;
          r_data[i] <= wb_data0;
        end
        if (wb_valid1 && (wb_tag1 == 3'(i)) && r_valid[i]) begin
          r_done[i] <= 1'b1;
          r_data[i] <= wb_data1;
        end
        if ((w_ret0 && (w_h0 == 3'(i))) || (w_ret1 && (w_h1 == 3'(i)))) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
        if (w_alloc0 && (w_t0 == 3'(i))) begin
          r_valid[i]  <= 1'b1;
          r_done[i]   <= 1'b0;
          r_writes[i] <= alloc_writes0;
          r_dest[i]   <= alloc_dest0;
        end
        if (w_alloc1 && (w_t1 == 3'(i))) begin
          r_valid[i]  <= 1'b1;
          r_done[i]   <= 1'b0;
          r_writes[i] <= alloc_writes1;
          r_dest[i]   <= alloc_dest1;
        end
      end

      commit_we0   <= w_ret0 & r_writes[w_h0];
      commit_addr0 <= w_ret0 ? r_dest[w_h0] : 3'd0;
      commit_data0 <= w_ret0 ? r_data[w_h0] : '0;
      commit_we1   <= w_ret1 & r_writes[w_h1];
      commit_addr1 <= w_ret1 ? r_dest[w_h1] : 3'd0;
      commit_data1 <= w_ret1 ? r_data[w_h1] : '0;
      commit_count <= w_ret_n;

      r_head  <= r_head + {2'b00, w_ret_n};
      r_tail  <= r_tail + {2'b00, w_alloc_n};
      r_count <= r_count + {2'b00, w_alloc_n} - {2'b00, w_ret_n};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_buffer_v2.sv
//------------------------------------------------------------------------------
// Module   : tb_commit_buffer_v2
// Purpose  : Self-checking bench for commit_buffer_v2 (vector table + scoreboard).
// Revision : 2.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_commit_buffer_v2;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        alloc_valid0, alloc_valid1, alloc_writes0, alloc_writes1;
  logic [2:0]  alloc_dest0, alloc_dest1;
  logic        alloc_ready;
  logic [2:0]  alloc_tag0, alloc_tag1;
  logic        wb_valid0, wb_valid1;
  logic [2:0]  wb_tag0, wb_tag1;
  logic [15:0] wb_data0, wb_data1;
  logic        commit_we0, commit_we1;
  logic [2:0]  commit_addr0, commit_addr1;
  logic [15:0] commit_data0, commit_data1;
  logic [1:0]  commit_count;
  logic        empty, full;

  always #5 clock = ~clock;

  commit_buffer_v2 #(.DEPTH(8), .DW(16)) u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid0(alloc_valid0), .alloc_valid1(alloc_valid1),
    .alloc_writes0(alloc_writes0), .alloc_writes1(alloc_writes1),
    .alloc_dest0(alloc_dest0), .alloc_dest1(alloc_dest1),
    .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .wb_valid0(wb_valid0), .wb_valid1(wb_valid1),
    .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .commit_we0(commit_we0), .commit_we1(commit_we1),
    .commit_addr0(commit_addr0), .commit_addr1(commit_addr1),
    .commit_data0(commit_data0), .commit_data1(commit_data1),
    .commit_count(commit_count), .empty(empty), .full(full)
  );

  typedef struct {
    logic        fl, av0, av1, wr0, wr1;
    logic [2:0]  d0, d1;
    logic        wv0, wv1;
    logic [2:0]  wt0, wt1;
    logic [15:0] wd0, wd1;
    logic [2:0]  xtag;
    logic [1:0]  xcnt;
    logic        xemp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard: allocation-order tag queue plus per-tag expected payload.
  logic        m_valid [8];
  logic        m_done  [8];
  logic        m_wr    [8];
  logic [2:0]  m_dest  [8];
  logic [15:0] m_data  [8];
  logic [3:0]  m_tail;
  int          q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_tail = 4'd0;
    q.delete();
  endtask

  task automatic chk_slot(input int s, input logic ewe, input logic [2:0] ea, input logic [15:0] ed);
    if (s == 0) begin
      chk("we0", 32'(commit_we0), 32'(ewe));
      chk("addr0", 32'(commit_addr0), 32'(ea));
      chk("data0", 32'(commit_data0), 32'(ed));
    end else begin
      chk("we1", 32'(commit_we1), 32'(ewe));
      chk("addr1", 32'(commit_addr1), 32'(ea));
      chk("data1", 32'(commit_data1), 32'(ed));
    end
  endtask

  task automatic step(input vec_t v, input logic rn);
    int         xret;
    logic       acc0, acc1;
    logic [2:0] t;
    reset = rn; flush = v.fl;
    alloc_valid0 = v.av0; alloc_valid1 = v.av1;
    alloc_writes0 = v.wr0; alloc_writes1 = v.wr1;
    alloc_dest0 = v.d0; alloc_dest1 = v.d1;
    wb_valid0 = v.wv0; wb_valid1 = v.wv1;
    wb_tag0 = v.wt0; wb_tag1 = v.wt1;
    wb_data0 = v.wd0; wb_data1 = v.wd1;
    #1;
    xret = 0;
    if (rn && !v.fl && q.size() >= 1 && m_done[q[0]]) begin
      xret = 1;
      if (q.size() >= 2 && m_done[q[1]]) xret = 2;
    end
    acc0 = rn && !v.fl && v.av0 && (q.size() <= 6);
    acc1 = acc0 && v.av1;
    chk("pre_tag0", 32'(alloc_tag0), 32'(m_tail[2:0]));
    chk("pre_tag1", 32'(alloc_tag1), 32'(3'(m_tail[2:0] + 3'd1)));
    chk("pre_ready", 32'(alloc_ready), 32'(q.size() <= 6));
    @(posedge clock);
    #1;
    chk("commit_count", 32'(commit_count), 32'(xret));
    for (int s = 0; s < 2; s++) begin
      if (s < xret) begin
        t = 3'(q.pop_front());
        chk_slot(s, m_wr[t], m_dest[t], m_data[t]);
        m_valid[t] = 1'b0;
        m_done[t]  = 1'b0;
      end else begin
        chk_slot(s, 1'b0, 3'd0, 16'd0);
      end
    end
    if (!rn || v.fl) begin
      model_clear();
    end else begin
      if (v.wv0 && m_valid[v.wt0]) begin m_done[v.wt0] = 1'b1; m_data[v.wt0] = v.wd0; end
      if (v.wv1 && m_valid[v.wt1]) begin m_done[v.wt1] = 1'b1; m_data[v.wt1] = v.wd1; end
      if (acc0) begin
        t = m_tail[2:0];
        m_valid[t] = 1'b1; m_done[t] = 1'b0; m_wr[t] = v.wr0; m_dest[t] = v.d0;
        q.push_back(int'(t)); m_tail = m_tail + 4'd1;
      end
      if (acc1) begin
        t = m_tail[2:0];
        m_valid[t] = 1'b1; m_done[t] = 1'b0; m_wr[t] = v.wr1; m_dest[t] = v.d1;
        q.push_back(int'(t)); m_tail = m_tail + 4'd1;
      end
    end
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 8));
  endtask

  task automatic alloc_pair(input logic [2:0] d0, input logic [2:0] d1);
    vec_t v;
    v = idle_v();
    v.av0 = 1'b1; v.av1 = 1'b1; v.wr0 = 1'b1; v.wr1 = 1'b1; v.d0 = d0; v.d1 = d1;
    step(v, 1'b1);
  endtask

  // Write back the two oldest pending entries per cycle until the buffer empties.
  task automatic drain(input string nm);
    vec_t v;
    int   picked;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      v = idle_v();
      picked = 0;
      foreach (q[j]) begin
        if (picked < 2 && !m_done[q[j]]) begin
          if (picked == 0) begin
            v.wv0 = 1'b1; v.wt0 = 3'(q[j]); v.wd0 = 16'($urandom);
          end else begin
            v.wv1 = 1'b1; v.wt1 = 3'(q[j]); v.wd1 = 16'($urandom);
          end
          picked++;
        end
      end
      step(v, 1'b1);
    end
    chk({nm, "_left"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_we0"}, 32'(commit_we0), 32'd0);
    chk({nm, "_we1"}, 32'(commit_we1), 32'd0);
    chk({nm, "_addr0"}, 32'(commit_addr0), 32'd0);
    chk({nm, "_addr1"}, 32'(commit_addr1), 32'd0);
    chk({nm, "_data0"}, 32'(commit_data0), 32'd0);
    chk({nm, "_data1"}, 32'(commit_data1), 32'd0);
    chk({nm, "_count"}, 32'(commit_count), 32'd0);
    chk({nm, "_empty"}, 32'(empty), 32'd1);
    chk({nm, "_full"}, 32'(full), 32'd0);
    chk({nm, "_ready"}, 32'(alloc_ready), 32'd1);
    chk({nm, "_tag0"}, 32'(alloc_tag0), 32'd0);
    chk({nm, "_tag1"}, 32'(alloc_tag1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [17];
    vec_t v;
    int   nu;
    int   und[$];

    //            fl    av0   av1   wr0   wr1   d0    d1    wv0   wv1   wt0   wt1   wd0       wd1       xtag  xcnt  xemp
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd1, 3'd0, 16'hBEEF, 16'h0000, 3'd2, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h0000, 3'd2, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd2, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd2, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2, 3'd2, 16'hAAAA, 16'h5555, 3'd3, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd3, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd3, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd3, 16'h0000, 16'h0F0F, 3'd4, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd4, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd4, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4, 3'd5, 16'h1111, 16'h2222, 3'd6, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd6, 2'd2, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b1, 3'd6, 3'd0, 16'hDEAD, 16'hDEAD, 3'd6, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd7, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd6, 3'd0, 16'h3333, 16'h0000, 3'd7, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'd7, 2'd1, 1'b1};

    model_clear();
    step(idle_v(), 1'b0);
    step(idle_v(), 1'b0);
    chk_reset_vals("rst");

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("tbl%0d_tag0", i), 32'(alloc_tag0), 32'(tbl[i].xtag));
      step(tbl[i], 1'b1);
      chk($sformatf("tbl%0d_cnt", i), 32'(commit_count), 32'(tbl[i].xcnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].xemp));
    end

    // Fill to eight, then confirm further dispatch is refused and tail holds.
    for (int k = 0; k < 4; k++) alloc_pair(3'(k), 3'(k + 4));
    chk("full_at_8", 32'(full), 32'd1);
    chk("ready_at_8", 32'(alloc_ready), 32'd0);
    v = idle_v(); v.av0 = 1'b1; v.wr0 = 1'b1;
    step(v, 1'b1);
    step(v, 1'b1);
    chk("tail_held", 32'(alloc_tag0), 32'd7);
    v = idle_v(); v.wv0 = 1'b1; v.wt0 = 3'(q[0]); v.wd0 = 16'hC0DE;
    step(v, 1'b1);
    v = idle_v(); v.av0 = 1'b1;
    step(v, 1'b1);
    chk("ready_at_7", 32'(alloc_ready), 32'd0);
    step(v, 1'b1);
    chk("tail_held_7", 32'(alloc_tag0), 32'd7);
    drain("drain_full");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) alloc_pair(3'($urandom), 3'($urandom));
      chk($sformatf("round%0d_full", r), 32'(full), 32'd1);
      drain($sformatf("round%0d", r));
      chk($sformatf("round%0d_empty", r), 32'(empty), 32'd1);
    end

    // Random mix: concurrent allocation with out-of-order writebacks.
    for (int c = 0; c < 120; c++) begin
      v = idle_v();
      if ($urandom_range(0, 3) != 0) begin
        v.av0 = 1'b1; v.av1 = 1'($urandom_range(0, 1));
        v.wr0 = 1'($urandom_range(0, 1)); v.wr1 = 1'($urandom_range(0, 1));
        v.d0 = 3'($urandom); v.d1 = 3'($urandom);
      end
      und.delete();
      foreach (q[j]) if (!m_done[q[j]]) und.push_back(q[j]);
      nu = und.size();
      if (nu > 0 && $urandom_range(0, 1) == 1) begin
        v.wv0 = 1'b1; v.wt0 = 3'(und[$urandom_range(0, nu - 1)]); v.wd0 = 16'($urandom);
      end
      if (nu > 0 && $urandom_range(0, 1) == 1) begin
        v.wv1 = 1'b1; v.wt1 = 3'(und[$urandom_range(0, nu - 1)]); v.wd1 = 16'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        v.wv1 = 1'b1; v.wt1 = 3'($urandom); v.wd1 = 16'($urandom);
      end
      step(v, 1'b1);
    end
    drain("rand");

    // Flush with done entries pending, plus competing alloc and writeback.
    alloc_pair(3'd1, 3'd2);
    v = idle_v(); v.wv0 = 1'b1; v.wt0 = 3'(q[0]); v.wd0 = 16'h1111;
    v.wv1 = 1'b1; v.wt1 = 3'(q[1]); v.wd1 = 16'h2222;
    step(v, 1'b1);
    v = idle_v(); v.fl = 1'b1; v.av0 = 1'b1; v.wr0 = 1'b1; v.wv0 = 1'b1; v.wt0 = 3'(q[0]);
    step(v, 1'b1);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_cnt", 32'(commit_count), 32'd0);
    chk("flush_tag0", 32'(alloc_tag0), 32'd0);
    step(idle_v(), 1'b1);
    chk("post_flush_cnt", 32'(commit_count), 32'd0);

    alloc_pair(3'd3, 3'd4);
    v = idle_v(); v.wv0 = 1'b1; v.wt0 = 3'(q[0]); v.wd0 = 16'h3333;
    v.wv1 = 1'b1; v.wt1 = 3'(q[1]); v.wd1 = 16'h4444;
    step(v, 1'b1);
    v = idle_v(); v.fl = 1'b1; v.av0 = 1'b1; v.wr0 = 1'b1; v.wv0 = 1'b1; v.wt0 = 3'(q[0]);
    step(v, 1'b0);
    chk_reset_vals("midrst");
    step(idle_v(), 1'b1);
    chk("post_rst_cnt", 32'(commit_count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
